// File: rtl/regfile_preload.sv
// Register-file preloader: walks a (last, reg, data) ROM, writes each entry through the
// regfile test port, reads it back, and holds the processor in reset while running.
module regfile_preload #(
    parameter int NUM_ENTRIES = 8,
    parameter int ADDR_W      = 6,
    parameter bit SKIP_R0     = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [37:0]       rom_q,
    input  logic [31:0]       t_data_readRegA,
    output logic              test,
    output logic              t_ctrl_writeEnable,
    output logic [4:0]        t_ctrl_writeReg,
    output logic [31:0]       t_data_writeReg,
    output logic [4:0]        t_ctrl_readRegA,
    output logic              proc_reset_hold,
    output logic              busy,
    output logic              done,
    output logic [6:0]        write_count,
    output logic [7:0]        error_count
);

    typedef enum logic [2:0] {
        IDLE, FETCH, LATCH, WRITE, VERIFY, CHECK_END, DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_ENTRIES - 1);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic              e_last;
    logic [4:0]        e_reg;
    logic [31:0]       e_data;

    // idx is itself a register, so the ROM address needs no extra flop
    assign rom_addr        = idx;
    assign test            = busy;
    assign proc_reset_hold = busy;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            idx                <= '0;
            e_last             <= 1'b0;
            e_reg              <= '0;
            e_data             <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            write_count        <= '0;
            error_count        <= '0;
            t_ctrl_writeEnable <= 1'b0;
            t_ctrl_writeReg    <= '0;
            t_data_writeReg    <= '0;
            t_ctrl_readRegA    <= '0;
        end else begin
            // test-port strobes are one-state pulses; each state re-asserts what it needs
            t_ctrl_writeEnable <= 1'b0;
            t_ctrl_writeReg    <= '0;
            t_data_writeReg    <= '0;
            t_ctrl_readRegA    <= '0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= FETCH;
                        idx         <= '0;
                        write_count <= '0;
                        error_count <= '0;
                        done        <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                FETCH: state <= LATCH;
                LATCH: begin
                    e_last <= rom_q[37];
                    e_reg  <= rom_q[36:32];
                    e_data <= rom_q[31:0];
                    if (SKIP_R0 && rom_q[36:32] == 5'd0) begin
                        state <= CHECK_END;
                    end else begin
                        state              <= WRITE;
                        t_ctrl_writeEnable <= 1'b1;
                        t_ctrl_writeReg    <= rom_q[36:32];
                        t_data_writeReg    <= rom_q[31:0];
                    end
                end
                WRITE: begin
                    write_count     <= write_count + 7'd1;
                    t_ctrl_readRegA <= e_reg;
                    state           <= VERIFY;
                end
                VERIFY: begin
                    if (t_data_readRegA != e_data && error_count != 8'hFF)
                        error_count <= error_count + 8'd1;
                    state <= CHECK_END;
                end
                CHECK_END: begin
                    if (e_last || idx == LAST_IDX) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        idx   <= idx + ADDR_W'(1);
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/regfile_preload.md
# regfile_preload

Hardware register-file preloader for the processor skeleton: the writer side of the regfile test port that the testbench reads back through `check_register`. On `start` it walks a ROM of (register, value) entries and writes each into the register file through the skeleton's test-port mux (`test`, `t_ctrl_writeEnable`, `t_ctrl_writeReg`, `t_data_writeReg`), reading each entry back on `t_ctrl_readRegA` to confirm it. While the block runs it holds the processor in reset, so a program starts from a known register state.

## Interface
- `NUM_ENTRIES`, default 8: ROM depth in entries, range 1..64.
- `ADDR_W`, default 6: ROM address width; must satisfy 2^ADDR_W >= NUM_ENTRIES.
- `SKIP_R0`, default 1: when 1, entries that target r0 are skipped and not written.

- `clock` in 1: single clock, rising-edge.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: one-cycle request to begin a preload; ignored while `busy`.
- `rom_addr` out ADDR_W: ROM entry index, registered.
- `rom_q` in 38: ROM data with 1-cycle synchronous read latency. Fields: [37] last, [36:32] reg, [31:0] data.
- `t_data_readRegA` in 32: regfile port-A data, combinational read.
- `test` out 1: skeleton mux select; 1 routes the test port into the regfile.
- `t_ctrl_writeEnable` out 1: regfile write enable.
- `t_ctrl_writeReg` out 5: regfile write index.
- `t_data_writeReg` out 32: regfile write data.
- `t_ctrl_readRegA` out 5: readback index.
- `proc_reset_hold` out 1: active-high hold for processor reset, equal to `busy`.
- `busy` out 1: a preload is in progress.
- `done` out 1: sticky; the last preload completed.
- `write_count` out 7: number of entries written in the last preload.
- `error_count` out 8: readback mismatches in the last preload; saturates at 255.

## Operation
- The FSM has these states: IDLE, FETCH, LATCH, WRITE, VERIFY, CHECK_END, DONE.
- **IDLE**
  - All outputs are 0.
  - `start` moves to FETCH and clears `idx`, `write_count`, `error_count` and `done`.
- **FETCH:** `rom_addr` = `idx`. Next state is LATCH.
- **LATCH**
  - Captures `rom_q` into `e_last`, `e_reg`, `e_data`.
  - If `SKIP_R0` and `e_reg`==0, next state is CHECK_END. Otherwise next state is WRITE.
- **WRITE**
  - `t_ctrl_writeEnable`=1, `t_ctrl_writeReg`=`e_reg`, `t_data_writeReg`=`e_data`.
  - The regfile commits on the closing edge.
  - `write_count` increments. Next state is VERIFY.
- **VERIFY**
  - `t_ctrl_readRegA`=`e_reg`, and `t_data_readRegA` is compared with `e_data`.
  - A mismatch increments `error_count`, saturating at 255.
  - Next state is CHECK_END.
- **CHECK_END**
  - If `e_last` or `idx`==`NUM_ENTRIES`-1, next state is DONE.
  - Otherwise `idx` increments and the next state is FETCH.
- **DONE:** `done`=1, `busy`=0, `test`=0. `start` restarts the preload exactly as from IDLE.
- `test`, `busy` and `proc_reset_hold` are 1 in every state except IDLE and DONE.
- `t_ctrl_writeEnable` is 1 only in WRITE. Outside WRITE the write index and write data are driven to 0.
- When `SKIP_R0`=0, r0 entries are written and verified; the expected readback is 0, so each one counts as an error if `e_data`≠0.
- Duplicate registers in the ROM: the later entry wins; each duplicate is verified against its own data.

## Timing
- All outputs are registered or decoded from the state register. There are no combinational paths from `start` or `rom_q` to any output.
- `start` sampled at edge 0 gives `busy`=1 after edge 0.
- Cycle cost per entry:
  - Written entry: 5 cycles.
  - Skipped entry: 3 cycles.
  - For N written entries, `done` rises after edge 5N.
- `rom_q` is sampled only in LATCH, one cycle after `rom_addr` changes.
- `start` while `busy` has no effect. `start` in the same cycle as completion (CHECK_END→DONE) is ignored.
- Reset (`reset`=0), including mid-operation:
  - Immediately forces IDLE and all outputs to 0.
  - `t_ctrl_writeEnable` drops asynchronously, so no partial write commits after reset asserts.
  - Counters clear, and `done` returns to 0.
- Wrap: `idx` never exceeds `NUM_ENTRIES`-1. A ROM with no `last` bit terminates after the final index.

## Test plan
- **Basic preload:** ROM = {r1=0x0000FFFF}, {r2=0x12345678, last}. Pulse `start`. Required response:
  - `done` after 10 cycles.
  - `write_count`=2, `error_count`=0.
  - Bench reads r1=65535 and r2=0x12345678.
- **R0 skip:** ROM = {r0=5}, {r3=7, last} with `SKIP_R0`=1. Required response:
  - No `t_ctrl_writeEnable` pulse for r0.
  - `done` after 8 cycles, `write_count`=1, r0=0, r3=7.
- **Forced mismatch:** bench corrupts `t_data_readRegA` during VERIFY of r4 (ROM r4=0xA5A5A5A5). Required response: `error_count`=1, `done`=1.
- **Reset mid-run:** assert `reset` low while in WRITE of entry 2. Required response:
  - `t_ctrl_writeEnable`, `busy`, `test` and `proc_reset_hold` are 0 within the same cycle.
  - `done`=0 and the counters read 0.
  - A subsequent `start` completes normally.
- **Busy-ignore and restart:** pulse `start` again at cycle 3 of a run. Required response:
  - No restart; `write_count` is final.
  - `start` in DONE reruns the preload, and `done` drops for the duration of the rerun.
- **No-last ROM:** `NUM_ENTRIES`=8 with every `last`=0. Required response: exactly 8 entries are processed, `done` after 40 cycles, and `rom_addr` never exceeds 7.
